// File: rtl/uart_rx_fifo.sv
// UART receiver on a single clock: 2-flop synchroniser, mid-bit sampling FSM,
// optional parity and 1/2 stop bits, feeding a first-word-fall-through FIFO.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_i,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_frame_err,
  output logic                          rx_parity_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int   CW      = $clog2(CLKS_PER_BIT);
  localparam int   BW      = $clog2(DATA_BITS + 1);
  localparam int   PW      = $clog2(FIFO_DEPTH);
  localparam int   NW      = PW + 1;
  localparam int   EW      = DATA_BITS + 2;
  localparam logic PAR_EXP = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_next;
  logic                 rx_meta, rx_s;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 frame_err_r, parity_err_r;
  logic                 tick, push;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    if (state == S_START) tick = (clk_cnt == CW'(CLKS_PER_BIT / 2 - 1));
    else                  tick = (clk_cnt == CW'(CLKS_PER_BIT - 1));
    case (state)
      S_IDLE:   if (!rx_s) state_next = S_START;
      S_START:  if (tick) state_next = rx_s ? S_IDLE : S_DATA;
      S_DATA:   if (tick && bit_cnt == BW'(DATA_BITS - 1))
                  state_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_next = S_STOP;
      S_STOP:   if (tick && bit_cnt == BW'(STOP_BITS - 1)) begin
                  push       = 1'b1;
                  state_next = S_IDLE;
                end
      default:  state_next = S_IDLE;
    endcase
  end

  // Data shifts in from the top so the first (LSB) bit lands at bit 0 after DATA_BITS samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_cnt      <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          clk_cnt      <= '0;
          bit_cnt      <= '0;
          frame_err_r  <= 1'b0;
          parity_err_r <= 1'b0;
        end
        S_DATA: begin
          clk_cnt <= tick ? '0 : clk_cnt + CW'(1);
          if (tick) begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= (bit_cnt == BW'(DATA_BITS - 1)) ? '0 : bit_cnt + BW'(1);
          end
        end
        S_PARITY: begin
          clk_cnt <= tick ? '0 : clk_cnt + CW'(1);
          if (tick) parity_err_r <= ((^shift_reg) ^ rx_s) != PAR_EXP;
        end
        S_STOP: begin
          clk_cnt <= tick ? '0 : clk_cnt + CW'(1);
          if (tick) begin
            frame_err_r <= frame_err_r | ~rx_s;
            bit_cnt     <= bit_cnt + BW'(1);
          end
        end
        default: clk_cnt <= tick ? '0 : clk_cnt + CW'(1);
      endcase
    end
  end

  assign busy = (state != S_IDLE);

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] word_in, head, last_q;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  logic          full, pop, wr_en, drop;

  assign word_in = {frame_err_r | ~rx_s, parity_err_r, shift_reg};
  assign full    = (count == NW'(FIFO_DEPTH));
  assign pop     = rx_valid & rx_ready;
  assign wr_en   = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= word_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      last_q  <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        last_q <= mem[rd_ptr];
      end
      count <= count + NW'(wr_en) - NW'(pop);
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

  // When empty, the outputs keep showing the most recently consumed word.
  assign head          = (count != '0) ? mem[rd_ptr] : last_q;
  assign rx_data       = head[DATA_BITS-1:0];
  assign rx_parity_err = head[DATA_BITS];
  assign rx_frame_err  = head[DATA_BITS+1];
  assign rx_valid      = (count != '0);
  assign fifo_count    = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: three receivers (plain, even parity, two stop bits) driven by
// directed frames; per-receiver monitors compare popped words against queues.
module tb_uart_rx_fifo;
  localparam int CPB = 16;

  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;

  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic ready0 = 1'b1, ready1 = 1'b1, ready2 = 1'b1;
  logic clr0 = 1'b0, clr1 = 1'b0, clr2 = 1'b0;
  logic [7:0] data0, data1, data2;
  logic fe0, fe1, fe2, pe0, pe1, pe2, v0, v1, v2, ov0, ov1, ov2, busy0, busy1, busy2;
  logic [2:0] cnt0, cnt1, cnt2;

  int tests = 0, fails = 0;
  logic [9:0] q0[$], q1[$], q2[$];
  logic [9:0] e0, e1, e2;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB)) dut0 (
    .clk(clk), .reset(reset), .rx_i(rx0), .rx_data(data0), .rx_frame_err(fe0),
    .rx_parity_err(pe0), .rx_valid(v0), .rx_ready(ready0), .overrun(ov0),
    .clr_overrun(clr0), .busy(busy0), .fifo_count(cnt0));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .PARITY(2)) dut1 (
    .clk(clk), .reset(reset), .rx_i(rx1), .rx_data(data1), .rx_frame_err(fe1),
    .rx_parity_err(pe1), .rx_valid(v1), .rx_ready(ready1), .overrun(ov1),
    .clr_overrun(clr1), .busy(busy1), .fifo_count(cnt1));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .rx_i(rx2), .rx_data(data2), .rx_frame_err(fe2),
    .rx_parity_err(pe2), .rx_valid(v2), .rx_ready(ready2), .overrun(ov2),
    .clr_overrun(clr2), .busy(busy2), .fifo_count(cnt2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 one bit period later.
  task automatic drive_bit(input int which, input logic v);
    case (which)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int which, input logic [7:0] d, input int npar,
                            input logic pbit, input int nstop, input logic [1:0] stopv);
    drive_bit(which, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
    if (npar != 0) drive_bit(which, pbit);
    for (int i = 0; i < nstop; i++) drive_bit(which, stopv[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && v0 && ready0) begin
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL mon0: unexpected word %h, expected none", {fe0, pe0, data0});
      end else begin
        e0 = q0.pop_front();
        if ({fe0, pe0, data0} !== e0) begin
          fails++;
          $display("FAIL mon0: got %h, expected %h", {fe0, pe0, data0}, e0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && v1 && ready1) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL mon1: unexpected word %h, expected none", {fe1, pe1, data1});
      end else begin
        e1 = q1.pop_front();
        if ({fe1, pe1, data1} !== e1) begin
          fails++;
          $display("FAIL mon1: got %h, expected %h", {fe1, pe1, data1}, e1);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && v2 && ready2) begin
      tests++;
      if (q2.size() == 0) begin
        fails++;
        $display("FAIL mon2: unexpected word %h, expected none", {fe2, pe2, data2});
      end else begin
        e2 = q2.pop_front();
        if ({fe2, pe2, data2} !== e2) begin
          fails++;
          $display("FAIL mon2: got %h, expected %h", {fe2, pe2, data2}, e2);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bsy;
    idle(3);
    check("reset_valid", v0, 0);
    check("reset_data", data0, 0);
    check("reset_count", cnt0, 0);
    check("reset_busy", busy0, 0);
    reset = 1'b0;
    idle(4);

    // Single frame: latency from start-bit edge to rx_valid, busy duration
    q0.push_back({2'b00, 8'hA5});
    fork
      send_frame(0, 8'hA5, 0, 1'b0, 1, 2'b11);
      begin
        wait (rx0 == 1'b0);
        lat = 0;
        bsy = 0;
        while (!v0 && lat < 400) begin
          @(posedge clk);
          #1;
          lat++;
          if (busy0) bsy++;
        end
      end
    join
    check("valid_latency", lat, 155);
    check("busy_cycles", bsy, 152);
    idle(20);

    // Short glitch is rejected as a false start
    rx0 = 1'b0;
    idle(4);
    rx0 = 1'b1;
    idle(20);
    check("glitch_count", cnt0, 0);
    check("glitch_busy", busy0, 0);
    q0.push_back({2'b00, 8'h3C});
    send_frame(0, 8'h3C, 0, 1'b0, 1, 2'b11);
    idle(20);

    // Even parity
    q1.push_back({2'b00, 8'h07});
    send_frame(1, 8'h07, 1, 1'b1, 1, 2'b11);
    q1.push_back({2'b01, 8'h07});
    send_frame(1, 8'h07, 1, 1'b0, 1, 2'b11);
    idle(20);

    // Two stop bits, second one low
    q2.push_back({2'b10, 8'h55});
    send_frame(2, 8'h55, 0, 1'b0, 2, 2'b01);
    rx2 = 1'b1;
    idle(40);
    check("stop2_busy", busy2, 0);

    // Overrun: five back-to-back frames into a four-deep FIFO
    ready0 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) q0.push_back({2'b00, 8'(i)});
      send_frame(0, 8'(i), 0, 1'b0, 1, 2'b11);
    end
    idle(20);
    check("ovr_count", cnt0, 4);
    check("ovr_flag", ov0, 1);
    ready0 = 1'b1;
    for (int i = 0; i < 20 && v0; i++) idle(1);
    check("drain_count", cnt0, 0);
    check("ovr_held", ov0, 1);
    clr0 = 1'b1;
    idle(1);
    clr0 = 1'b0;
    check("ovr_clear", ov0, 0);

    // Reset mid-frame with a word buffered
    ready0 = 1'b0;
    send_frame(0, 8'h11, 0, 1'b0, 1, 2'b11);
    idle(4);
    check("pre_reset_count", cnt0, 1);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
    check("mid_busy", busy0, 1);
    reset = 1'b1;
    #1;
    check("async_valid", v0, 0);
    check("async_data", data0, 0);
    check("async_errs", {fe0, pe0, ov0}, 0);
    check("async_busy", busy0, 0);
    check("async_count", cnt0, 0);
    rx0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    ready0 = 1'b1;
    idle(10);
    q0.push_back({2'b00, 8'h81});
    send_frame(0, 8'h81, 0, 1'b0, 1, 2'b11);
    idle(20);
    check("post_reset_count", cnt0, 0);

    // Simultaneous pop and push while full
    ready0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q0.push_back({2'b00, 8'h10 + 8'(i)});
      send_frame(0, 8'h10 + 8'(i), 0, 1'b0, 1, 2'b11);
    end
    idle(16);
    check("full_count", cnt0, 4);
    q0.push_back({2'b00, 8'h14});
    fork
      send_frame(0, 8'h14, 0, 1'b0, 1, 2'b11);
      begin
        wait (rx0 == 1'b0);
        repeat (154) @(posedge clk);
        #1;
        ready0 = 1'b1;
        @(posedge clk);
        #1;
        ready0 = 1'b0;
        check("pushpop_count", cnt0, 4);
        check("pushpop_ovr", ov0, 0);
      end
    join
    ready0 = 1'b1;
    for (int i = 0; i < 20 && v0; i++) idle(1);
    check("final_count", cnt0, 0);

    idle(40);
    check("q0_left", q0.size(), 0);
    check("q1_left", q1.size(), 0);
    check("q2_left", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver that replaces the fixed 8-bit, divided-clock receiver. It runs entirely on clk, using an internal bit-period counter, a mid-bit sampling point and a glitch-rejecting start check. It supports configurable data width, optional parity and 1 or 2 stop bits. Received words, with their per-word error flags, are buffered in a small FIFO and drained through a valid/ready handshake by the downstream consumer (command decoder / display logic).

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (434 gives 115200 baud at 50 MHz); must be >= 4
DATA_BITS, 8, data bits per frame (5..9), LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, word slots; must be a power of two, >= 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rx_i  in  1  serial input; asynchronous to clk; idles high
rx_data  out  DATA_BITS  FIFO head word
rx_frame_err  out  1  head word had a low stop bit
rx_parity_err  out  1  head word failed the parity check (always 0 when PARITY = 0)
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer accepts the head word when rx_valid && rx_ready at posedge clk
overrun  out  1  sticky flag: a word was dropped because the FIFO was full
clr_overrun  in  1  synchronous clear of overrun
busy  out  1  receiver FSM is not in IDLE
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of words held

Behaviour:
- Reset is asynchronous:
  - FSM goes to IDLE; FIFO is emptied; counters are cleared.
  - Outputs: rx_valid = 0, rx_data = 0, both err flags = 0, overrun = 0, busy = 0, fifo_count = 0.
  - The synchroniser flops reset to 1.
  - Reset in the middle of a frame abandons that frame. No partial word is ever pushed.
- rx_i passes through a 2-flop synchroniser (rx_s). All detection uses rx_s, which adds 2 cycles of input latency.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when rx_s = 0, go to START and load bit_cnt = 0, clk_cnt = 0.
  - START: at clk_cnt = CLKS_PER_BIT/2 - 1 (mid start bit), sample rx_s.
    - If the sample is 1: false start; return to IDLE and push nothing.
    - If the sample is 0: reset clk_cnt and go to DATA.
  - DATA: every CLKS_PER_BIT cycles (mid-bit), shift rx_s into shift_reg[bit_cnt] and increment bit_cnt.
    - After DATA_BITS samples, go to PARITY if PARITY != 0, else go to STOP.
  - PARITY: sample one bit.
    - parity_err = (XOR of data bits XOR sampled bit) != expected.
    - Expected value: 1 for odd, 0 for even.
  - STOP: sample STOP_BITS bits, one bit period apart. frame_err = 1 if any stop sample is 0.
    - On the last stop sample: push {frame_err, parity_err, shift_reg} in the same cycle, then go to IDLE.
    - Returning to IDLE at mid-stop allows back-to-back frames with no idle gap.
- Latency: the pushed word appears at rx_valid on the clk edge after the last stop-bit sample.
- A frame with errors is still pushed, with its flags set.
- busy = (state != IDLE).
- FIFO:
  - Circular buffer; read/write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Word is first-word-fall-through: rx_data and the err flags show the head entry whenever rx_valid = 1.
  - Pop occurs on rx_valid && rx_ready. rx_ready while empty is ignored.
  - Push while fifo_count = FIFO_DEPTH and no pop in the same cycle: the word is dropped and overrun is set to 1.
  - Push and pop in the same cycle:
    - If full: the push is accepted and the count is unchanged; no overrun.
    - If empty: no pop occurs; the push lands and rx_valid = 1 on the next cycle.
  - rx_data holds its last value when empty. Consumers must qualify it with rx_valid.
- overrun clears only via reset or clr_overrun. If clr_overrun and a drop occur in the same cycle, set wins.
- Bit timing uses integer counting only; no fractional baud.

Test Plan:
1. Bench uses CLKS_PER_BIT = 16, defaults otherwise. Send 0xA5 with 1 stop bit -> one word 0xA5; frame_err = 0, parity_err = 0; rx_valid rises 1 clk after the mid-stop sample; busy is high for about 9.5 bit times.
2. Low glitch of 4 clk on rx_i while idle -> false start rejected; no push, fifo_count stays 0; then send 0x3C -> 0x3C received.
3. PARITY = 2 (even): send 0x07 with parity bit 1 -> parity_err = 0. Send 0x07 with parity bit 0 -> parity_err = 1, data = 0x07.
4. STOP_BITS = 2: send 0x55 with the second stop bit driven low -> word 0x55 pushed with frame_err = 1.
5. rx_ready held 0; send 5 back-to-back frames 0x01..0x05 -> fifo_count = 4, overrun = 1; drain yields 0x01..0x04 in order. Pulse clr_overrun -> overrun = 0.
6. Assert reset mid-DATA of 0xFF -> all outputs return to reset values; next frame 0x81 is received correctly. Simultaneous pop and push when full -> fifo_count stays 4, overrun stays 0.
